uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Receive-side controller for the UART receiver: generates its 16x-oversample clock enable from a
//  runtime baud divisor, buffers received bytes in a FIFO, and latches overflow/frame/parity/break
//  status as sticky flags. Adds an idle-line timeout and a combined interrupt request.
//  Sits between uart_rx and the CPU-bus register block.
// PARAMETERS
//  Depth      16   FIFO depth in bytes; power of 2, >= 2
//  IdleBits   40   bit periods (16 ticks each) with no push/pop before idle timeout fires
//  IrqLevel   8    FIFO fill level (1..Depth) at or above which the interrupt is raised
// PORTS
//  clk_i            in   1   system clock
//  reset_n_i        in   1   synchronous reset, active low
//  enable_i         in   1   1 = baud generator and timeout run; 0 = frozen
//  baud_div_i       in   16  oversample tick period = baud_div_i+1 clk cycles
//  uart_clk_en_o    out  1   1-cycle oversample tick, to uart_rx uart_clk_en_i
//  rx_data_i        in   8   byte from uart_rx
//  rx_valid_i       in   1   good byte strobe from uart_rx
//  rx_frame_err_i   in   1   frame error strobe from uart_rx
//  rx_parity_err_i  in   1   parity error strobe from uart_rx
//  rd_en_i          in   1   pop head of FIFO (ignored when empty)
//  rd_data_o        out  8   FIFO head, first-word-fall-through; valid when empty_o=0
//  empty_o / full_o out  1   FIFO state
//  count_o          out  $clog2(Depth)+1  bytes held
//  clr_status_i     in   1   clears all sticky flags
//  overflow_o       out  1   sticky: byte dropped because FIFO full
//  frame_err_o      out  1   sticky: frame error seen
//  parity_err_o     out  1   sticky: parity error seen
//  break_o          out  1   sticky: frame error with rx_data_i == 8'h00
//  idle_irq_o       out  1   idle timeout level
//  irq_o            out  1   combined interrupt
// BEHAVIOUR
//  Reset: all outputs 0 except empty_o=1; FIFO pointers, baud counter, timeout counter cleared.
//  Baud gen: 16-bit counter; enable_i=0 holds it at 0, no ticks. Tick and counter<=0 when
//   counter >= baud_div_i (>= so a lowered divisor never causes a 65536-cycle stall); else +1.
//   baud_div_i=0 -> tick every cycle. Divisor change takes effect immediately via the compare.
//  FIFO: push on rx_valid_i & ~full. rx_valid_i & full -> byte dropped, overflow_o set.
//   Pop on rd_en_i & ~empty; rd_en_i when empty is a no-op. Push and pop in the same cycle:
//   both happen, count unchanged, including when full (push accepted) and empty (push only).
//   rd_data_o updates the cycle after a pop/push into empty; pointers wrap modulo Depth.
//  Sticky flags: set on their strobe; clr_status_i clears; set wins over clear in same cycle.
//   break_o set only when rx_frame_err_i and rx_data_i==0 (also sets frame_err_o).
//  Idle FSM (IDLE_WAIT, IDLE_COUNT, IDLE_FIRED), bit tick = every 16th oversample tick:
//   IDLE_WAIT: FIFO empty; -> IDLE_COUNT on push. IDLE_COUNT: counter +1 per bit tick;
//   push or pop reloads 0; reaching IdleBits -> IDLE_FIRED. IDLE_FIRED: idle_irq_o=1;
//   push or pop -> IDLE_COUNT (counter 0). Any state -> IDLE_WAIT when FIFO becomes empty.
//   enable_i=0 freezes counter and state. idle_irq_o registered, asserted in IDLE_FIRED only.
//  irq_o = (count_o >= IrqLevel) | idle_irq_o | overflow_o | frame_err_o | parity_err_o | break_o;
//   registered, 1 cycle after its sources.
//  Reset mid-byte: FIFO emptied, sticky flags cleared; a strobe in the reset cycle is discarded.
// STRUCTURE
//  uart_pkg: status bit-position localparams (OVF, FRM, PAR, BRK, IDLE) for the register block,
//   idle FSM state typedef idle_state_t.
//  Sub-module uart_rx_fifo (sync FIFO, Depth param, FWFT, push/pop/full/empty/count); baud
//   generator, sticky flags and idle FSM stay inline.
// TESTING
//  baud_div_i=3, enable_i=1 -> uart_clk_en_o every 4th cycle; enable_i=0 -> no ticks, counter 0.
//  Push 0x11..0x20 (16 bytes) with Depth=16 -> full_o=1, count_o=16; 17th push -> dropped,
//   overflow_o=1; pop all -> rd_data_o 0x11..0x20 in order, then empty_o=1.
//  Full FIFO, rx_valid_i and rd_en_i same cycle -> count_o stays 16, overflow_o stays 0.
//  rx_frame_err_i with rx_data_i=0x00 -> frame_err_o=1, break_o=1, irq_o=1 next cycle;
//   clr_status_i with simultaneous rx_parity_err_i -> parity_err_o stays 1, others clear.
//  One byte pushed, baud_div_i=0, IdleBits=40 -> idle_irq_o rises after 640 ticks; a pop
//   drops it and FIFO empty returns FSM to IDLE_WAIT.
//  reset_n_i low with 5 bytes buffered and flags set -> empty_o=1, count_o=0, all flags 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: status bit positions used by
// the CPU-bus register block and the idle-timeout FSM state type.
package uart_pkg;

  // Bit positions of the status word presented to the register block
  localparam int OVF      = 0;
  localparam int FRM      = 1;
  localparam int PAR      = 2;
  localparam int BRK      = 3;
  localparam int IDLE     = 4;
  localparam int STATUS_W = 5;

  // Idle-line timeout FSM states
  typedef enum logic [1:0] {
    IDLE_WAIT  = 2'd0,
    IDLE_COUNT = 2'd1,
    IDLE_FIRED = 2'd2
  } idle_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO, first-word-fall-through. The head byte is held in a
// register that is refreshed on a pop or on a push into an (effectively)
// empty FIFO. push_i/pop_i must already be qualified by the caller
// (no push when full unless popping, no pop when empty).
module uart_rx_fifo #(
  parameter int Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     push_i,
  input  logic [7:0]               wr_data_i,
  input  logic                     pop_i,
  output logic [7:0]               rd_data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    rd_data_q, rd_data_d;

  // Pointer/count update and next head byte (bypass when the pushed byte becomes the head)
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push_i && ((count_q == '0) || (pop_i && (count_q == CW'(1))))) begin
      rd_data_d = wr_data_i;
    end else if (pop_i) begin
      rd_data_d = mem_q[rd_ptr_d];
    end
  end

  // Storage array; contents need no reset because the pointers define validity
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointer, count and head registers
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign count_o   = count_q;
  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CW'(Depth));

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: oversample tick generator, receive FIFO, sticky
// error flags, idle-line timeout and the combined interrupt request.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int Depth    = 16,
  parameter int IdleBits = 40,
  parameter int IrqLevel = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   enable_i,
  input  logic [15:0]            baud_div_i,
  output logic                   uart_clk_en_o,
  input  logic [7:0]             rx_data_i,
  input  logic                   rx_valid_i,
  input  logic                   rx_frame_err_i,
  input  logic                   rx_parity_err_i,
  input  logic                   rd_en_i,
  output logic [7:0]             rd_data_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(Depth):0] count_o,
  input  logic                   clr_status_i,
  output logic                   overflow_o,
  output logic                   frame_err_o,
  output logic                   parity_err_o,
  output logic                   break_o,
  output logic                   idle_irq_o,
  output logic                   irq_o
);

  localparam int CW = $clog2(Depth) + 1;
  localparam int BW = $clog2(IdleBits + 1);
  localparam logic [BW-1:0] IDLE_LAST = BW'(IdleBits - 1);

  logic [15:0]   baud_cnt_q, baud_cnt_d;
  logic          tick_q, tick_d;
  logic [BRK:OVF] sticky_q, sticky_d;
  idle_state_t   state_q, state_d;
  logic [3:0]    sub_q, sub_d;
  logic [BW-1:0] bits_q, bits_d;
  logic          idle_irq_q, idle_irq_d;
  logic          irq_q, irq_d;
  logic          push, pop, drop, drains;

  // FIFO handshake: a full FIFO still accepts a byte when a pop frees a slot
  assign pop    = rd_en_i & ~empty_o;
  assign push   = rx_valid_i & (~full_o | pop);
  assign drop   = rx_valid_i & ~push;
  assign drains = pop & ~push & (count_o == CW'(1));

  uart_rx_fifo #(.Depth(Depth)) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (push),
    .wr_data_i (rx_data_i),
    .pop_i     (pop),
    .rd_data_o (rd_data_o),
    .empty_o   (empty_o),
    .full_o    (full_o),
    .count_o   (count_o)
  );

  // Baud counter: >= compare so lowering the divisor restarts promptly
  always_comb begin
    baud_cnt_d = baud_cnt_q;
    tick_d     = 1'b0;
    if (!enable_i) begin
      baud_cnt_d = '0;
    end else if (baud_cnt_q >= baud_div_i) begin
      tick_d     = 1'b1;
      baud_cnt_d = '0;
    end else begin
      baud_cnt_d = baud_cnt_q + 16'd1;
    end
  end

  // Sticky status: a new event in the same cycle as a clear survives
  always_comb begin
    sticky_d      = clr_status_i ? '0 : sticky_q;
    sticky_d[OVF] = sticky_d[OVF] | drop;
    sticky_d[FRM] = sticky_d[FRM] | rx_frame_err_i;
    sticky_d[PAR] = sticky_d[PAR] | rx_parity_err_i;
    sticky_d[BRK] = sticky_d[BRK] | (rx_frame_err_i & (rx_data_i == 8'h00));
  end

  // Idle FSM; counting only advances on ticks, so enable_i=0 freezes it
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    bits_d  = bits_q;
    case (state_q)
      IDLE_WAIT: begin
        sub_d  = '0;
        bits_d = '0;
        if (push) state_d = IDLE_COUNT;
      end
      IDLE_COUNT: begin
        if (push || pop) begin
          sub_d  = '0;
          bits_d = '0;
        end else if (tick_d) begin
          if (sub_q == 4'd15) begin
            sub_d = '0;
            if (bits_q == IDLE_LAST) begin
              bits_d  = '0;
              state_d = IDLE_FIRED;
            end else begin
              bits_d = bits_q + BW'(1);
            end
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
      end
      IDLE_FIRED: begin
        if (push || pop) begin
          sub_d   = '0;
          bits_d  = '0;
          state_d = IDLE_COUNT;
        end
      end
      default: state_d = IDLE_WAIT;
    endcase
    if (drains) begin
      state_d = IDLE_WAIT;
      sub_d   = '0;
      bits_d  = '0;
    end
    idle_irq_d = (state_d == IDLE_FIRED);
  end

  // Combined interrupt, computed from the already-registered sources
  always_comb begin
    irq_d = (count_o >= CW'(IrqLevel)) | idle_irq_q | (|sticky_q);
  end

  // All controller state registers
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      baud_cnt_q <= '0;
      tick_q     <= 1'b0;
      sticky_q   <= '0;
      state_q    <= IDLE_WAIT;
      sub_q      <= '0;
      bits_q     <= '0;
      idle_irq_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      tick_q     <= tick_d;
      sticky_q   <= sticky_d;
      state_q    <= state_d;
      sub_q      <= sub_d;
      bits_q     <= bits_d;
      idle_irq_q <= idle_irq_d;
      irq_q      <= irq_d;
    end
  end

  assign uart_clk_en_o = tick_q;
  assign overflow_o    = sticky_q[OVF];
  assign frame_err_o   = sticky_q[FRM];
  assign parity_err_o  = sticky_q[PAR];
  assign break_o       = sticky_q[BRK];
  assign idle_irq_o    = idle_irq_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed steps plus random FIFO/flag
// traffic compared against a queue-based reference model.
module tb_uart_rx_ctrl;

  localparam int DEPTH     = 16;
  localparam int IDLE_BITS = 40;
  localparam int IRQ_LEVEL = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] baud_div;
  logic        uart_clk_en;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_frame_err, rx_parity_err, rd_en, clr_status;
  logic [7:0]  rd_data;
  logic        empty, full;
  logic [4:0]  count;
  logic        overflow, frame_err, parity_err, brk, idle_irq, irq;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.Depth(DEPTH), .IdleBits(IDLE_BITS), .IrqLevel(IRQ_LEVEL)) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .enable_i        (enable),
    .baud_div_i      (baud_div),
    .uart_clk_en_o   (uart_clk_en),
    .rx_data_i       (rx_data),
    .rx_valid_i      (rx_valid),
    .rx_frame_err_i  (rx_frame_err),
    .rx_parity_err_i (rx_parity_err),
    .rd_en_i         (rd_en),
    .rd_data_o       (rd_data),
    .empty_o         (empty),
    .full_o          (full),
    .count_o         (count),
    .clr_status_i    (clr_status),
    .overflow_o      (overflow),
    .frame_err_o     (frame_err),
    .parity_err_o    (parity_err),
    .break_o         (brk),
    .idle_irq_o      (idle_irq),
    .irq_o           (irq)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] model_q[$];
  logic       ovf_m, frm_m, par_m, brk_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rx_valid = 0; rx_data = 8'h00; rd_en = 0;
    rx_frame_err = 0; rx_parity_err = 0; clr_status = 0;
  endtask

  // One bus cycle with model update and full output comparison
  task automatic cycle(input logic v, input logic [7:0] d, input logic rd,
                       input logic fe, input logic pe, input logic clr);
    bit pop_m, push_m, drop_m, irq_exp;
    rx_valid = v; rx_data = d; rd_en = rd;
    rx_frame_err = fe; rx_parity_err = pe; clr_status = clr;
    step();
    clear_inputs();
    irq_exp = (model_q.size() >= IRQ_LEVEL) || ovf_m || frm_m || par_m || brk_m;
    pop_m   = rd && (model_q.size() > 0);
    push_m  = v && ((model_q.size() < DEPTH) || pop_m);
    drop_m  = v && !push_m;
    if (pop_m)  void'(model_q.pop_front());
    if (push_m) model_q.push_back(d);
    ovf_m = (ovf_m && !clr) || drop_m;
    frm_m = (frm_m && !clr) || fe;
    par_m = (par_m && !clr) || pe;
    brk_m = (brk_m && !clr) || (fe && (d == 8'h00));
    $display("cyc v=%0d d=%02h rd=%0d fe=%0d pe=%0d clr=%0d -> cnt=%0d head=%02h st=%0d%0d%0d%0d irq=%0d",
             v, d, rd, fe, pe, clr, count, rd_data, overflow, frame_err, parity_err, brk, irq);
    check("count", count, model_q.size());
    check("empty", empty, model_q.size() == 0);
    check("full", full, model_q.size() == DEPTH);
    if (model_q.size() > 0) check("rd_data", rd_data, model_q[0]);
    check("overflow", overflow, ovf_m);
    check("frame_err", frame_err, frm_m);
    check("parity_err", parity_err, par_m);
    check("break", brk, brk_m);
    check("irq", irq, irq_exp);
    check("idle_irq_frozen", idle_irq, 1'b0);
  endtask

  // Tick expected on the step where (steps since enable) % (div+1) == div
  task automatic baud_check(input logic [15:0] div, input int n);
    enable = 0; baud_div = div;
    step(); step();
    check("tick_disabled", uart_clk_en, 1'b0);
    enable = 1;
    for (int i = 0; i < n; i++) begin
      step();
      check("tick_phase", uart_clk_en, (i % (div + 1)) == div);
    end
    $display("baud div=%0d checked %0d cycles", div, n);
    enable = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("tick_off", uart_clk_en, 1'b0);
    end
  endtask

  initial begin
    int n;
    int r;
    reset_n = 0; enable = 0; baud_div = 16'd0;
    clear_inputs();
    ovf_m = 0; frm_m = 0; par_m = 0; brk_m = 0;

    // Reset state
    step(); step();
    reset_n = 1;
    check("rst_empty", empty, 1'b1);
    check("rst_count", count, 0);
    check("rst_full", full, 1'b0);
    check("rst_flags", {overflow, frame_err, parity_err, brk, idle_irq, irq}, 6'b0);
    check("rst_tick", uart_clk_en, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    $display("reset state checked");

    // Baud generator
    baud_check(16'd3, 16);
    baud_check(16'($urandom_range(0, 6)), 20);
    baud_check(16'd0, 6);

    // Fill to full, overflow, clear, simultaneous push/pop when full, drain
    for (int i = 0; i < 16; i++) cycle(1, 8'(8'h11 + i), 0, 0, 0, 0);
    cycle(1, 8'h99, 0, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 0, 1);
    cycle(1, 8'h21, 1, 0, 0, 0);
    for (int i = 0; i < 17 && model_q.size() > 0; i++) cycle(0, 8'h00, 1, 0, 0, 0);
    cycle(0, 8'h00, 1, 0, 0, 0);

    // Break, then clear racing a parity strobe
    cycle(0, 8'h00, 0, 1, 0, 0);
    cycle(0, 8'h00, 0, 0, 0, 0);
    cycle(0, 8'h55, 0, 0, 1, 1);
    cycle(0, 8'h00, 0, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
    end

    // Reset with bytes buffered and flags set; strobes in the reset cycle are dropped
    for (int i = 0; i < 20 && model_q.size() > 0; i++) cycle(0, 8'h00, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 8'($urandom), 0, 0, 0, 0);
    cycle(0, 8'h00, 0, 1, 1, 0);
    reset_n = 0; rx_valid = 1; rx_data = 8'h00; rx_frame_err = 1; rx_parity_err = 1;
    step();
    reset_n = 1;
    clear_inputs();
    model_q.delete();
    ovf_m = 0; frm_m = 0; par_m = 0; brk_m = 0;
    check("mid_rst_empty", empty, 1'b1);
    check("mid_rst_count", count, 0);
    check("mid_rst_flags", {overflow, frame_err, parity_err, brk, idle_irq}, 5'b0);
    step();
    check("mid_rst_irq", irq, 1'b0);
    check("mid_rst_still_empty", empty, 1'b1);
    $display("reset with buffered data checked");

    // Idle timeout: one tick per cycle, 16 ticks per bit period
    enable = 1; baud_div = 16'd0;
    rx_valid = 1; rx_data = 8'hA5; step(); rx_valid = 0;
    r = $urandom_range(50, 500);
    repeat (r) step();
    check("idle_early", idle_irq, 1'b0);
    rx_valid = 1; rx_data = 8'h5A; step(); rx_valid = 0;
    n = 0;
    while (idle_irq !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    $display("idle fired %0d cycles after reloading push (gap %0d)", n, r);
    check("idle_latency", n, 16 * IDLE_BITS);
    check("irq_lags_idle", irq, 1'b0);
    step();
    check("irq_from_idle", irq, 1'b1);
    rd_en = 1; step(); rd_en = 0;
    check("idle_drop_on_pop", idle_irq, 1'b0);
    check("idle_pop_head", rd_data, 8'h5A);
    rd_en = 1; step(); rd_en = 0;
    check("idle_empty", empty, 1'b1);
    check("irq_after_idle", irq, 1'b0);
    repeat (700) step();
    check("idle_wait_quiet", idle_irq, 1'b0);
    check("irq_quiet", irq, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
